uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Receive-side counterpart of the sensor min/max report sender. Consumes bytes from the UART controller (rx_done/rx_data) and assembles newline-terminated ASCII command lines.
- Decodes each completed line into one-cycle control pulses: temp_start/humi_start report requests, min/max clear, and an 8-bit threshold write.
- Sits between the UART controller RX side and the sensor/report control logic.

Parameters:
- MAX_LEN, 8, line buffer depth in bytes, excluding the terminator; range 6..16.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_done  in  1  one-cycle strobe; rx_data is valid in the same cycle
- rx_data  in  8  received byte
- o_temp_start  out  1  one-cycle pulse on command "temp"
- o_humi_start  out  1  one-cycle pulse on command "humi"
- o_clr  out  1  one-cycle pulse on command "clr"
- o_thresh  out  8  last accepted threshold value; holds between writes
- o_thresh_valid  out  1  one-cycle pulse when o_thresh is updated
- o_cmd_err  out  1  one-cycle pulse on an unknown, malformed or overflowed line
- o_busy  out  1  high in DECODE/NUM; rx bytes are dropped while high

Behaviour:
- Reset: one clock, sync, active-high (fixed). All outputs 0, o_thresh = 0, state RECV, len = 0, overflow flag = 0, buffer contents don't-care.
- States: RECV, DECODE, NUM.
- RECV, rx_done with a non-terminator byte:
  - If len < MAX_LEN: buf[len] <= byte, len++.
  - Else: set the overflow flag, byte discarded.
- RECV, rx_done with terminator '\n' (8'h0A) or '\r' (8'h0D):
  - len == 0 and no overflow: ignored (empty line), stay in RECV. This makes "\r\n" yield exactly one command.
  - Otherwise: go to DECODE next cycle.
- Latency: terminator sampled in cycle T; DECODE is active in T+1.
- DECODE (one cycle):
  - Overflow flag set -> o_cmd_err at T+2.
  - Buffer is exactly "temp" / "humi" / "clr" (len must match) -> corresponding pulse at T+2.
  - buf[0..2] == "th " and len in 4..6 -> go to NUM with idx = 3, acc = 0.
  - Anything else -> o_cmd_err at T+2.
  - Every exit except to NUM returns to RECV with len = 0 and overflow cleared.
- NUM (one digit per cycle):
  - buf[idx] in '0'..'9': acc_next = acc*10 + digit, computed at 10-bit width. If acc_next > 255 -> error.
  - buf[idx] not a digit -> error.
  - After consuming idx == len-1: o_thresh <= acc and o_thresh_valid pulse.
  - With k digits, o_thresh_valid (or o_cmd_err) arrives at T+2+k. An error aborts immediately, pulse on the next cycle.
  - Then return to RECV with len = 0.
- Leading zeros are accepted ("th 007" = 7). On an error, o_thresh keeps its previous value.
- rx_done while o_busy: byte dropped silently and not buffered. A terminator is also dropped.
- At most one output pulse per line, and pulses never overlap.
- Reset asserted mid-line or mid-NUM: partial line discarded, no pulse emitted.
- Matching is case-sensitive, lowercase only, unless CASE_FOLD_EN is defined.

Optional Feature:
- Macro: UART_CMD_CASE_FOLD_EN.
- Defined: bytes 'A'..'Z' are converted to 'a'..'z' before being stored in the buffer, so "TEMP" and "Th 12" are accepted.
- Undefined: bytes are stored raw, and uppercase commands give o_cmd_err.
- Digit and terminator handling are identical in both builds.

Decomposition:
- Package uart_cmd_pkg holds:
  - ASCII constants: ASC_LF, ASC_CR, ASC_SP, ASC_0, ASC_9.
  - State encoding localparams: ST_RECV, ST_DECODE, ST_NUM.
  - Command keyword byte constants.
- Sub-module: ascii_to_digit (combinational). Input byte; outputs is_digit and 4-bit value. Instantiated once in NUM.
- Line buffer, counters and FSM stay in uart_cmd_parser.

Test Plan:
- Send "temp\n" (bytes spaced 20 cycles) -> o_temp_start high exactly 1 cycle, 2 cycles after the '\n' strobe; no other pulse.
- Send "humi\r\n" then "clr\n" -> one o_humi_start, then one o_clr; the empty line between '\r' and '\n' produces no o_cmd_err.
- Send "th 200\n" -> o_thresh = 8'd200 with o_thresh_valid at T+5. Then send "th 256\n" -> o_cmd_err, o_thresh stays 200.
- Send "th 1x\n", "tem\n", "abcdefghij\n" (MAX_LEN = 8) -> three o_cmd_err pulses; the next "temp\n" is still decoded correctly.
- Strobe a byte during o_busy (e.g. 1 cycle after "th 255\n" terminator) -> byte dropped, o_thresh = 255, next line unaffected. Assert reset after "hu" -> no pulse; then "humi\n" decodes normally.
- UART_CMD_CASE_FOLD_EN defined: "TEMP\n" -> o_temp_start. Undefined: same stimulus -> o_cmd_err.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command-line parser.
// Holds the ASCII constants, the FSM state type and the command keywords.
// Keywords are packed with the first character in the most significant byte.
package uart_cmd_pkg;

  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_9  = 8'h39;

  typedef enum logic [1:0] {
    ST_RECV,
    ST_DECODE,
    ST_NUM
  } state_e;

  localparam logic [31:0] KW_TEMP = "temp";
  localparam logic [31:0] KW_HUMI = "humi";
  localparam logic [23:0] KW_CLR  = "clr";
  localparam logic [23:0] KW_TH   = {"th", ASC_SP};

  function automatic logic is_term(input logic [7:0] b);
    return (b == ASC_LF) || (b == ASC_CR);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_ascii_to_digit.sv
// ascii_to_digit: combinational ASCII decimal digit decoder.
// Ports:
//   ch       in  8  ASCII byte
//   is_digit out 1  high when ch is '0'..'9'
//   value    out 4  numeric value of ch (meaningful only when is_digit)
module ascii_to_digit
  import uart_cmd_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_digit,
  output logic [3:0] value
);

  always_comb begin
    is_digit = (ch >= ASC_0) && (ch <= ASC_9);
    // '0' is 8'h30, so the low nibble of a digit is its value
    value    = ch[3:0];
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles newline-terminated ASCII command lines from the
// UART receiver and decodes them into one-cycle control pulses.
// Commands: "temp", "humi", "clr", "th <0..255>" (1..3 digits).
// Optional build macro UART_CMD_CASE_FOLD_EN: fold 'A'..'Z' to lowercase
// before buffering.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   rx_done, rx_data  received byte strobe and data
//   o_temp_start      pulse on "temp"
//   o_humi_start      pulse on "humi"
//   o_clr             pulse on "clr"
//   o_thresh          last accepted threshold
//   o_thresh_valid    pulse when o_thresh updates
//   o_cmd_err         pulse on unknown/malformed/overflowed line
//   o_busy            decoding in progress; incoming bytes are dropped
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int MAX_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       o_temp_start,
  output logic       o_humi_start,
  output logic       o_clr,
  output logic [7:0] o_thresh,
  output logic       o_thresh_valid,
  output logic       o_cmd_err,
  output logic       o_busy
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);
  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic            ovf_q, ovf_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      acc_q, acc_d;
  logic [7:0]      thresh_q, thresh_d;
  logic            temp_q, temp_d;
  logic            humi_q, humi_d;
  logic            clr_q, clr_d;
  logic            tv_q, tv_d;
  logic            err_q, err_d;
  logic [7:0]      line_q [MAX_LEN];
  logic [7:0]      line_d [MAX_LEN];

  logic [7:0]      rx_byte;
  logic [31:0]     head4;
  logic            dig_ok;
  logic [3:0]      dig_val;
  logic [9:0]      acc_next;
  logic            last_digit;

  always_comb begin
    rx_byte = rx_data;
`ifdef UART_CMD_CASE_FOLD_EN
    if (rx_data >= 8'h41 && rx_data <= 8'h5A) rx_byte = rx_data | 8'h20;
`endif
  end

  ascii_to_digit u_digit (
    .ch       (line_q[idx_q]),
    .is_digit (dig_ok),
    .value    (dig_val)
  );

  always_comb begin
    head4      = {line_q[0], line_q[1], line_q[2], line_q[3]};
    // at most three digits reach here, so 10 bits never wrap
    acc_next   = 10'(acc_q) * 10'd10 + 10'(dig_val);
    last_digit = (LW'(idx_q) == len_q - LW'(1));
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    thresh_d = thresh_q;
    line_d   = line_q;
    temp_d   = 1'b0;
    humi_d   = 1'b0;
    clr_d    = 1'b0;
    tv_d     = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_RECV: begin
        if (rx_done) begin
          if (is_term(rx_byte)) begin
            // empty line (e.g. the LF of CR/LF) is swallowed
            if (len_q != '0 || ovf_q) state_d = ST_DECODE;
          end else if (len_q < MAX_LEN_L) begin
            line_d[len_q[IW-1:0]] = rx_byte;
            len_d = len_q + LW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end

      ST_DECODE: begin
        state_d = ST_RECV;
        len_d   = '0;
        ovf_d   = 1'b0;
        if (ovf_q) begin
          err_d = 1'b1;
        end else if (len_q == LW'(4) && head4 == KW_TEMP) begin
          temp_d = 1'b1;
        end else if (len_q == LW'(4) && head4 == KW_HUMI) begin
          humi_d = 1'b1;
        end else if (len_q == LW'(3) && head4[31:8] == KW_CLR) begin
          clr_d = 1'b1;
        end else if (len_q >= LW'(4) && len_q <= LW'(6) && head4[31:8] == KW_TH) begin
          state_d = ST_NUM;
          len_d   = len_q;
          idx_d   = IW'(3);
          acc_d   = '0;
        end else begin
          err_d = 1'b1;
        end
      end

      ST_NUM: begin
        if (!dig_ok || acc_next > 10'd255) begin
          err_d   = 1'b1;
          state_d = ST_RECV;
          len_d   = '0;
        end else if (last_digit) begin
          thresh_d = acc_next[7:0];
          tv_d     = 1'b1;
          state_d  = ST_RECV;
          len_d    = '0;
        end else begin
          acc_d = acc_next[7:0];
          idx_d = idx_q + IW'(1);
        end
      end

      default: begin
        state_d = ST_RECV;
        len_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RECV;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
      thresh_q <= '0;
      temp_q   <= 1'b0;
      humi_q   <= 1'b0;
      clr_q    <= 1'b0;
      tv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      thresh_q <= thresh_d;
      temp_q   <= temp_d;
      humi_q   <= humi_d;
      clr_q    <= clr_d;
      tv_q     <= tv_d;
      err_q    <= err_d;
    end
  end

  // line contents are don't-care after reset
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  always_comb begin
    o_temp_start   = temp_q;
    o_humi_start   = humi_q;
    o_clr          = clr_q;
    o_thresh       = thresh_q;
    o_thresh_valid = tv_q;
    o_cmd_err      = err_q;
    o_busy         = (state_q != ST_RECV);
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: byte-level stimulus, a line-level
// reference model predicting each pulse and its cycle, and a monitor that
// pops predictions whenever the DUT emits a pulse.
module tb_uart_cmd_parser;

  localparam int MAX_LEN = 8;
  localparam int K_TEMP = 0, K_HUMI = 1, K_CLR = 2, K_THR = 3, K_ERR = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       o_temp_start, o_humi_start, o_clr, o_thresh_valid, o_cmd_err, o_busy;
  logic [7:0] o_thresh;

  always #5 clk = ~clk;

  uart_cmd_parser #(.MAX_LEN(MAX_LEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_done        (rx_done),
    .rx_data        (rx_data),
    .o_temp_start   (o_temp_start),
    .o_humi_start   (o_humi_start),
    .o_clr          (o_clr),
    .o_thresh       (o_thresh),
    .o_thresh_valid (o_thresh_valid),
    .o_cmd_err      (o_cmd_err),
    .o_busy         (o_busy)
  );

  typedef struct {
    int kind;
    int val;
    int cyc;
  } exp_t;

  exp_t             exp_q[$];
  byte unsigned     mline[$];
  int               cyc = 0;
  int               busy_end = 0;
  int               model_thr = 0;
  int               n_tests = 0;
  int               n_fail = 0;

  always @(posedge clk) cyc++;

  function automatic void check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic byte unsigned tb_fold(input byte unsigned b);
`ifdef UART_CMD_CASE_FOLD_EN
    if (b >= 8'd65 && b <= 8'd90) return b + 8'd32;
`endif
    return b;
  endfunction

  function automatic bit line_is(input string kw);
    if (mline.size() != kw.len()) return 1'b0;
    for (int i = 0; i < kw.len(); i++)
      if (mline[i] != kw[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Interprets the whole line: returns outcome and how many digits the DUT
  // walks through before reporting.
  function automatic void eval_line(output int kind, output int val, output int n);
    int acc;
    kind = K_ERR; val = 0; n = 0; acc = 0;
    if (mline.size() > MAX_LEN) return;
    if (line_is("temp")) begin kind = K_TEMP; return; end
    if (line_is("humi")) begin kind = K_HUMI; return; end
    if (line_is("clr"))  begin kind = K_CLR;  return; end
    if (mline.size() >= 4 && mline.size() <= 6 &&
        mline[0] == 8'h74 && mline[1] == 8'h68 && mline[2] == 8'h20) begin
      for (int i = 3; i < mline.size(); i++) begin
        n++;
        if (mline[i] < 8'h30 || mline[i] > 8'h39) return;
        acc = acc * 10 + (int'(mline[i]) - 48);
        if (acc > 255) return;
      end
      kind = K_THR;
      val  = acc;
    end
  endfunction

  function automatic void model_byte(input byte unsigned b, input int e);
    exp_t x;
    int k, v, n;
    if (e <= busy_end) return;   // DUT busy: byte dropped
    if (b == 8'h0A || b == 8'h0D) begin
      if (mline.size() == 0) return;
      eval_line(k, v, n);
      x.kind = k; x.val = v; x.cyc = e + 1 + n;
      exp_q.push_back(x);
      busy_end = e + 1 + n;
      mline.delete();
    end else begin
      mline.push_back(tb_fold(b));
    end
  endfunction

  task automatic send_byte(input byte unsigned b, input int gap);
    int e;
    repeat (gap) @(posedge clk);
    #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    rx_done = 1'b0;
    model_byte(b, e);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mline.delete();
    busy_end = 0;
    model_thr = 0;
  endtask

  // Monitor: pops one prediction per observed pulse.
  always @(negedge clk) begin
    int p, act;
    exp_t e;
    if (reset !== 1'b1) begin
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check("pulse_missing", -1, e.kind);
      end
      p = int'(o_temp_start) + int'(o_humi_start) + int'(o_clr) +
          int'(o_thresh_valid) + int'(o_cmd_err);
      if (p > 1) check("pulse_overlap", p, 1);
      if (p >= 1) begin
        act = o_temp_start ? K_TEMP : o_humi_start ? K_HUMI : o_clr ? K_CLR :
              o_thresh_valid ? K_THR : K_ERR;
        if (exp_q.size() == 0) begin
          check("pulse_unexpected", act, -1);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", act, e.kind);
          check("pulse_cycle", cyc, e.cyc);
          if (e.kind == K_THR) model_thr = e.val;
          check("thresh_value", int'(o_thresh), model_thr);
        end
      end
    end
  end

  initial begin
    string s;
    int    r, len, gap;
    reset   = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_temp", int'(o_temp_start), 0);
    check("rst_humi", int'(o_humi_start), 0);
    check("rst_clr", int'(o_clr), 0);
    check("rst_tv", int'(o_thresh_valid), 0);
    check("rst_err", int'(o_cmd_err), 0);
    check("rst_thresh", int'(o_thresh), 0);
    check("rst_busy", int'(o_busy), 0);

    send_str("temp\n", 20);
    send_str($sformatf("humi%c\n", 8'h0D), 20);
    send_str("clr\n", 20);
    send_str("th 200\n", 20);
    send_str("th 256\n", 20);
    send_str("th 1x\n", 20);
    send_str("tem\n", 20);
    send_str("abcdefghij\n", 20);
    send_str("temp\n", 20);
    send_str("th 007\n", 5);
    send_str("th 0\n", 5);
    send_str("th 1234\n", 5);
    send_str("th \n", 5);
    send_str("th 255\n", 3);
    send_byte(8'h78, 0);          // lands while the DUT is busy
    send_str("temp\n", 3);
    wait_drain();
    check("thresh_hold_255", int'(o_thresh), 255);

    send_str("hu", 4);
    do_reset();
    check("mid_reset_thresh", int'(o_thresh), 0);
    check("mid_reset_busy", int'(o_busy), 0);
    send_str("humi\n", 4);
    send_str("TEMP\n", 4);
    send_str("Th 12\n", 4);

    for (int t = 0; t < 60; t++) begin
      r   = $urandom_range(0, 7);
      gap = $urandom_range(0, 3);
      case (r)
        0: s = "temp\n";
        1: s = $sformatf("humi%c\n", 8'h0D);
        2: s = "clr\n";
        3: s = $sformatf("th %0d\n", $urandom_range(0, 400));
        4: begin
          s = "";
          len = $urandom_range(1, 12);
          for (int i = 0; i < len; i++)
            s = {s, $sformatf("%c", 8'(97 + $urandom_range(0, 25)))};
          s = {s, "\n"};
        end
        5: s = ($urandom_range(0, 1) == 1) ? "TEMP\n" : "Clr\n";
        6: s = $sformatf("th %c%c\n", 8'(48 + $urandom_range(0, 9)),
                         8'(($urandom_range(0, 3) == 0) ? 120 : 48 + $urandom_range(0, 9)));
        default: s = $sformatf("%c\n", 8'h0D);
      endcase
      send_str(s, gap);
    end

    wait_drain();
    check("final_thresh", int'(o_thresh), model_thr);
    check("final_busy", int'(o_busy), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
